// File: rtl/btn_sched_pkg.sv
// Shared definitions for the front-panel button scheduler.
//   state_t      : scheduler FSM state encoding (S_IDLE / S_PRESENT)
//   DEB_CMAX_DEF : default debounce count (5 ms at a 50 MHz clk)
package btn_sched_pkg;

    localparam int DEB_CMAX_DEF = 250_000;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/btn_sched_if.sv
// Key-event handshake between the scheduler and its consumer FSM.
//   ev_valid : event presented (scheduler -> consumer)
//   ev_code  : index of the presented button (scheduler -> consumer)
//   ev_ready : consumer accepts when ev_valid && ev_ready (consumer -> scheduler)
interface btn_sched_if
    import btn_sched_pkg::*;
#(
    parameter int CW = 2
);
    logic          ev_valid;
    logic [CW-1:0] ev_code;
    logic          ev_ready;

    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/btn_sched_button.sv
// Debounced push button with press-edge lock sampling.
//   clk, rst_n : system clock, synchronous active-low reset
//   a_btn      : raw asynchronous button level
//   lock       : when high at the debounced press edge, that press yields no trigger
//   tr_btn     : one-cycle trigger pulse on the debounced release edge
module btn_sched_button
    import btn_sched_pkg::*;
#(
    parameter int DEB_CMAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_btn,
    input  logic lock,
    output logic tr_btn
);

    localparam int CNTW = (DEB_CMAX < 1) ? 1 : $clog2(DEB_CMAX + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DEB_CMAX);

    logic            sync1, sync2;
    logic            db_level;
    logic            armed;
    logic [CNTW-1:0] cnt;

    // The debounce timer is a down-counter reloaded whenever the synchronised
    // input agrees with the accepted level; a change is accepted only once the
    // input has disagreed long enough for the counter to reach zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            armed    <= 1'b0;
            cnt      <= CNT_LOAD;
            tr_btn   <= 1'b0;
        end else begin
            sync1  <= a_btn;
            sync2  <= sync1;
            tr_btn <= 1'b0;
            if (sync2 == db_level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                db_level <= sync2;
                cnt      <= CNT_LOAD;
                if (sync2) begin
                    // lock is sampled here only; a later drop does not re-arm
                    armed <= !lock;
                end else begin
                    tr_btn <= armed;
                    armed  <= 1'b0;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_sched.sv
// Front-panel button-bank scheduler.
//   clk, rst_n : system clock, synchronous active-low reset
//   a_btn[N]   : raw button inputs, one debouncer each
//   lock       : global lock forwarded to every button (blocks new events only)
//   flush      : drop all pending events and any presented event
//   ev         : key-event handshake (master side)
//   pend[N]    : pending-event bits
//   busy       : event presented or anything pending
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | nothing presented; picks next pending button
// S_PRESENT | ev_code presented with ev_valid=1, awaiting ev_ready
module btn_sched
    import btn_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int CW       = $clog2(N),
    parameter int DEB_CMAX = DEB_CMAX_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_btn,
    input  logic         lock,
    input  logic         flush,
    btn_sched_if.master  ev,
    output logic [N-1:0] pend,
    output logic         busy
);

    state_t        state, state_nxt;
    logic [N-1:0]  tr;
    logic [N-1:0]  lock_btn;
    logic [N-1:0]  pend_clr;
    logic [N-1:0]  sel_oh;
    logic [CW-1:0] code_q;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] rr_nxt;
    logic [CW-1:0] sel;
    logic [CW:0]   idx;
    logic [CW:0]   code_inc;
    logic          any_pend;
    logic          ev_valid;
    logic          take;
    logic          accept;
    logic          clear_all;

    for (genvar gi = 0; gi < N; gi++) begin : g_btn
        // a button cannot queue again while its event is pending or in flight
        assign lock_btn[gi] = lock | pend[gi] | (ev_valid && code_q == CW'(gi));

        btn_sched_button #(
            .DEB_CMAX (DEB_CMAX)
        ) u_button (
            .clk    (clk),
            .rst_n  (rst_n),
            .a_btn  (a_btn[gi]),
            .lock   (lock_btn[gi]),
            .tr_btn (tr[gi])
        );
    end

    // Round-robin pick: first pending bit at or after rr_ptr, wrapping at N.
    // Iterating downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        any_pend = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (idx >= (CW+1)'(N)) begin
                idx = idx - (CW+1)'(N);
            end
            if (pend[idx[CW-1:0]]) begin
                any_pend = 1'b1;
                sel      = idx[CW-1:0];
            end
        end
    end

    // Compare against N rather than relying on CW-bit overflow so rr_ptr
    // never leaves 0..N-1 when N is not a power of two.
    assign code_inc = {1'b0, code_q} + (CW+1)'(1);
    assign rr_nxt   = (code_inc >= (CW+1)'(N)) ? '0 : code_inc[CW-1:0];
    assign sel_oh   = N'(1) << sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!flush && any_pend) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (flush || ev.ev_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ev_valid  = 1'b0;
        take      = 1'b0;
        accept    = 1'b0;
        clear_all = flush;
        case (state)
            S_IDLE: begin
                take = !flush && any_pend;
            end
            S_PRESENT: begin
                ev_valid = 1'b1;
                accept   = !flush && ev.ev_ready;
            end
            default: ;
        endcase
    end

    assign pend_clr = clear_all ? '1 : (take ? sel_oh : '0);

    // Trigger OR-ed in after the clear: a same-cycle set always wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend   <= '0;
            code_q <= '0;
            rr_ptr <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | tr;
            if (take) begin
                code_q <= sel;
            end
            if (accept) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    assign ev.ev_valid = ev_valid;
    assign ev.ev_code  = code_q;
    assign busy        = ev_valid | (|pend);

endmodule

// File: tb/tb_btn_sched.sv
module tb_btn_sched;
    import btn_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_btn;
    logic       lock;
    logic       flush;
    logic [3:0] pend;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    logic [1:0] acc[$];

    btn_sched_if #(.CW(2)) bus ();

    btn_sched #(
        .N        (4),
        .CW       (2),
        .DEB_CMAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_btn (a_btn),
        .lock  (lock),
        .flush (flush),
        .ev    (bus),
        .pend  (pend),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // accepted events, sampled half a cycle before the edge that takes them
    always @(negedge clk) begin
        if (rst_n && bus.ev_valid && bus.ev_ready && !flush) begin
            acc.push_back(bus.ev_code);
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_ev(output logic [31:0] v);
        if (acc.size() > 0) v = 32'(acc.pop_front());
        else                v = 32'hFF;
    endtask

    task automatic press(input logic [3:0] mask);
        a_btn = mask;
        tick(20);
        a_btn = 4'b0000;
        tick(20);
    endtask

    task automatic wait_pend(input string tag);
        for (int k = 0; k < 40 && pend == 4'b0000; k++) tick();
        chk(tag, 32'(pend != 4'b0000), 32'd1);
    endtask

    logic [31:0] v;
    int          bad;

    initial begin
        rst_n        = 1'b0;
        a_btn        = 4'b0000;
        lock         = 1'b0;
        flush        = 1'b0;
        bus.ev_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_pend",  32'(pend),         32'd0);
        chk("rst_code",  32'(bus.ev_code),  32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        rst_n = 1'b1;
        tick(2);

        // single press of button 2, consumer always ready
        bus.ev_ready = 1'b1;
        a_btn = 4'b0100;
        tick(20);
        a_btn = 4'b0000;
        wait_pend("t1_pend_seen");
        chk("t1_pend",      32'(pend),         32'h4);
        chk("t1_valid_pre", 32'(bus.ev_valid), 32'd0);
        tick();
        chk("t1_valid",     32'(bus.ev_valid), 32'd1);
        chk("t1_code",      32'(bus.ev_code),  32'd2);
        chk("t1_pend_clr",  32'(pend),         32'd0);
        tick();
        chk("t1_valid_off", 32'(bus.ev_valid), 32'd0);
        tick(10);
        chk("t1_count", 32'(acc.size()), 32'd1);
        take_ev(v);
        chk("t1_ev",    v,               32'd2);
        chk("t1_busy",  32'(busy),       32'd0);

        // round-robin from rr_ptr=0 over pend=1011
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        bus.ev_ready = 1'b0;
        a_btn = 4'b1011;
        tick(20);
        a_btn = 4'b0000;
        wait_pend("t2_pend_seen");
        chk("t2_pend",  32'(pend), 32'hB);
        tick();
        chk("t2_code0", 32'(bus.ev_code), 32'd0);
        chk("t2_pend1", 32'(pend),        32'hA);
        tick(5);
        chk("t2_hold",  32'({bus.ev_valid, bus.ev_code}), 32'h4);
        bus.ev_ready = 1'b1;
        tick(20);
        chk("t2_count", 32'(acc.size()), 32'd3);
        take_ev(v); chk("t2_ev0", v, 32'd0);
        take_ev(v); chk("t2_ev1", v, 32'd1);
        take_ev(v); chk("t2_ev2", v, 32'd3);
        press(4'b1001);
        chk("t2b_count", 32'(acc.size()), 32'd2);
        take_ev(v); chk("t2b_ev0", v, 32'd0);
        take_ev(v); chk("t2b_ev1", v, 32'd3);

        // backpressure: button 1 in flight, re-pressed while stalled
        bus.ev_ready = 1'b0;
        press(4'b0010);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 5)  a_btn = 4'b0010;
            if (k == 25) a_btn = 4'b0000;
            tick();
            if (!(bus.ev_valid === 1'b1 && bus.ev_code === 2'd1)) bad++;
        end
        chk("t3_stable", 32'(bad),  32'd0);
        chk("t3_pend",   32'(pend), 32'd0);
        bus.ev_ready = 1'b1;
        tick(20);
        chk("t3_count", 32'(acc.size()), 32'd1);
        take_ev(v); chk("t3_ev", v, 32'd1);

        // global lock: button 3 pressed under lock, button 0 already queued
        bus.ev_ready = 1'b0;
        press(4'b0010);
        press(4'b0001);
        chk("t4_pend0", 32'(pend),        32'h1);
        chk("t4_code",  32'(bus.ev_code), 32'd1);
        lock  = 1'b1;
        a_btn = 4'b1000;
        tick(20);
        chk("t4_pend_lock",  32'(pend),         32'h1);
        chk("t4_valid_lock", 32'(bus.ev_valid), 32'd1);
        lock  = 1'b0;
        a_btn = 4'b0000;
        tick(20);
        chk("t4_no_btn3", 32'(pend), 32'h1);
        bus.ev_ready = 1'b1;
        tick(20);
        chk("t4_count", 32'(acc.size()), 32'd2);
        take_ev(v); chk("t4_ev0", v, 32'd1);
        take_ev(v); chk("t4_ev1", v, 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // flush while presenting, new trigger on button 0 during flush
        bus.ev_ready = 1'b0;
        press(4'b0010);
        press(4'b0100);
        chk("t5_pend_pre", 32'(pend), 32'h4);
        chk("t5_pres_pre", 32'({bus.ev_valid, bus.ev_code}), 32'h5);
        a_btn = 4'b0001;
        tick(20);
        a_btn = 4'b0000;
        tick();
        flush = 1'b1;
        tick();
        chk("t5_flush_valid", 32'(bus.ev_valid), 32'd0);
        chk("t5_flush_pend",  32'(pend),         32'd0);
        wait_pend("t5_pend_seen");
        chk("t5_set_wins", 32'(pend),         32'h1);
        chk("t5_idle",     32'(bus.ev_valid), 32'd0);
        flush = 1'b0;
        tick();
        chk("t5_pres", 32'({bus.ev_valid, bus.ev_code}), 32'h4);
        bus.ev_ready = 1'b1;
        tick(20);
        chk("t5_count", 32'(acc.size()), 32'd1);
        take_ev(v); chk("t5_ev", v, 32'd0);

        // reset mid-handshake
        bus.ev_ready = 1'b0;
        press(4'b1000);
        press(4'b0100);
        chk("t6_pre", 32'({bus.ev_valid, pend}), 32'h14);
        rst_n = 1'b0;
        tick();
        chk("t6_valid", 32'(bus.ev_valid), 32'd0);
        chk("t6_pend",  32'(pend),         32'd0);
        chk("t6_code",  32'(bus.ev_code),  32'd0);
        chk("t6_busy",  32'(busy),         32'd0);
        rst_n = 1'b1;
        bus.ev_ready = 1'b1;
        tick(40);
        chk("t6_no_stale", 32'(acc.size()), 32'd0);
        chk("t6_busy_end", 32'(busy),       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
